// File: rtl/mem_ctrl_slave.sv
// mem_ctrl_slave: bus-side memory controller on the multiplexed AddrData bus.
// Claims address phases whose page field matches PAGE, then runs a fixed
// 4-beat read or write burst against an internal MEMSIZE x BUSWIDTH array.

package mcDefs;
  localparam logic [3:0] MEMPAGE1 = 4'h2;

  // Bus address split: upper nibble selects the slave page, rest is the word.
  typedef struct packed {
    logic [3:0]  page;
    logic [11:0] loc;
  } memAddr_t;
endpackage

module mem_ctrl_slave #(
  parameter int         BUSWIDTH        = 16,
  parameter int         DATAPAYLOADSIZE = 4,
  parameter int         MEMSIZE         = 4096,
  parameter logic [3:0] PAGE            = mcDefs::MEMPAGE1
) (
  input  logic                clk,
  input  logic                resetH,
  input  logic                AddrValid,
  input  logic                rw,
  input  logic [BUSWIDTH-1:0] AddrData_in,
  output logic [BUSWIDTH-1:0] AddrData_out,
  output logic                AddrData_oe,
  output logic                busy
);

  localparam int LOCW = $clog2(MEMSIZE);
  localparam int CNTW = $clog2(DATAPAYLOADSIZE);
  localparam logic [CNTW-1:0] LAST = CNTW'(DATAPAYLOADSIZE - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t               state;
  logic [LOCW-1:0]      loc;
  logic [CNTW-1:0]      cnt;
  logic [BUSWIDTH-1:0]  mem [MEMSIZE];

  mcDefs::memAddr_t     ain;
  logic [LOCW-1:0]      cur_addr;
  logic [LOCW-1:0]      nxt_addr;
  logic                 hit;

  assign ain      = AddrData_in;
  assign hit      = AddrValid && (ain.page == PAGE);
  // Burst addresses wrap inside the page; the page bits never carry.
  assign cur_addr = loc + LOCW'(cnt);
  assign nxt_addr = cur_addr + LOCW'(1);

  // Array write port: one beat per cycle while in WRITE. Not reset, and a
  // reset edge suppresses the beat so an aborted burst drops its remainder.
  always_ff @(posedge clk) begin
    if (!resetH && state == WRITE)
      mem[cur_addr] <= AddrData_in;
  end

  // Burst FSM with registered bus outputs; read data is prefetched one beat
  // ahead so AddrData_out is stable for the whole beat the CPU samples.
  always_ff @(posedge clk) begin
    if (resetH) begin
      state        <= IDLE;
      cnt          <= '0;
      busy         <= 1'b0;
      AddrData_oe  <= 1'b0;
      AddrData_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            loc  <= ain.loc;
            cnt  <= '0;
            busy <= 1'b1;
            if (rw) begin
              state        <= READ;
              AddrData_out <= mem[ain.loc];
              AddrData_oe  <= 1'b1;
            end else begin
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          cnt <= cnt + CNTW'(1);
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        READ: begin
          cnt <= cnt + CNTW'(1);
          if (cnt == LAST) begin
            state        <= IDLE;
            busy         <= 1'b0;
            AddrData_oe  <= 1'b0;
            AddrData_out <= '0;
          end else begin
            AddrData_out <= mem[nxt_addr];
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          AddrData_oe  <= 1'b0;
          AddrData_out <= '0;
        end
      endcase
    end
  end

endmodule
